ysyx_22051013_ifu_fetch: RTL and testbench

//  Instruction fetch stage: owns the PC, issues one-outstanding fetches to imem, predecodes each returned word
//  (static predictor) and drives the IF/ID register (inst_o/pc_o/bpu_jump_o/if_valid) into the decode stage.

---
 rtl/ysyx_22051013_ifu_fetch_pkg.sv | 28 ++
 rtl/ysyx_22051013_ifu_fetch_if.sv | 36 +++
 rtl/ysyx_22051013_ifu_predecode.sv | 24 ++
 rtl/ysyx_22051013_ifu_fetch.sv | 147 ++++++++++++++
 tb/tb_ysyx_22051013_ifu_fetch.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22051013_ifu_fetch_pkg.sv
// Shared constants, state encoding and immediate helpers for the instruction fetch unit.
// The predecoder and the fetch top both import this package.
package ysyx_22051013_ifu_fetch_pkg;

   localparam int PC_W   = 64;
   localparam int INST_W = 32;

   localparam logic [PC_W-1:0] RESET_PC_DEF = 64'h8000_0000;
   localparam logic [PC_W-1:0] ZERO64       = 64'h0;

   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } ifu_state_e;

   function automatic logic [PC_W-1:0] imm_j(input logic [INST_W-1:0] inst);
      return {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   endfunction

   function automatic logic [PC_W-1:0] imm_b(input logic [INST_W-1:0] inst);
      return {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   endfunction

endpackage

// File: rtl/ysyx_22051013_ifu_fetch_if.sv
// Bundle of the imem request/response channel, the decode redirect/backpressure inputs
// and the IF/ID register outputs. The fetch unit is the master side.
interface ysyx_22051013_ifu_fetch_if;
   import ysyx_22051013_ifu_fetch_pkg::*;

   // Request: a transfer happens on a clock edge where imem_req_valid & imem_req_ready;
   // imem_addr stays stable while valid is high and unaccepted. Response is a 1-cycle pulse.
   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [PC_W-1:0]   imem_addr;
   logic              imem_resp_valid;
   logic [INST_W-1:0] imem_resp_data;

   logic              jump_ena;
   logic [PC_W-1:0]   jump_pc;
   logic              id_ready;
   logic              id_stall;

   logic              if_valid;
   logic [INST_W-1:0] inst_o;
   logic [PC_W-1:0]   pc_o;
   logic              bpu_jump_o;

   modport master (
      output imem_req_valid, imem_addr, if_valid, inst_o, pc_o, bpu_jump_o,
      input  imem_req_ready, imem_resp_valid, imem_resp_data,
      input  jump_ena, jump_pc, id_ready, id_stall
   );

   modport slave (
      input  imem_req_valid, imem_addr, if_valid, inst_o, pc_o, bpu_jump_o,
      output imem_req_ready, imem_resp_valid, imem_resp_data,
      output jump_ena, jump_pc, id_ready, id_stall
   );

endinterface

// File: rtl/ysyx_22051013_ifu_predecode.sv
// Static predictor: JAL is always followed, backward branches are predicted taken,
// everything else falls through to pc+4.
module ysyx_22051013_ifu_predecode
   import ysyx_22051013_ifu_fetch_pkg::*;
(
   input  logic [INST_W-1:0] inst,
   input  logic [PC_W-1:0]   pc,
   output logic [PC_W-1:0]   next_pc,
   output logic              bpu_jump
);

   always_comb begin
      next_pc  = pc + 64'd4;
      bpu_jump = 1'b0;
      if (inst[6:0] == OPC_JAL) begin
         // JAL is resolved entirely here, so decode is not told it was a jump
         next_pc = pc + imm_j(inst);
      end else if (inst[6:0] == OPC_BRANCH && inst[31]) begin
         next_pc  = pc + imm_b(inst);
         bpu_jump = 1'b1;
      end
   end

endmodule

// File: rtl/ysyx_22051013_ifu_fetch.sv
// Fetch stage: PC register, single-outstanding imem fetch FSM, orphan-response drop flag,
// one-entry skid buffer and the IF/ID output register feeding decode.
module ysyx_22051013_ifu_fetch
   import ysyx_22051013_ifu_fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   ysyx_22051013_ifu_fetch_if.master bus,
   output ifu_state_e           state_dbg
);

   ifu_state_e        state, state_next;
   logic [PC_W-1:0]   pc, pc_next;
   logic              drop, drop_next;
   logic              req_valid;
   logic              hs;
   logic              resp_in;
   logic              resp_take;
   logic              consume;

   logic [PC_W-1:0]   pd_next_pc;
   logic              pd_bpu;

   logic              out_valid;
   logic [INST_W-1:0] out_inst;
   logic [PC_W-1:0]   out_pc;
   logic              out_bpu;

   logic              skid_valid;
   logic [INST_W-1:0] skid_inst;
   logic [PC_W-1:0]   skid_pc;
   logic              skid_bpu;

   ysyx_22051013_ifu_predecode u_predecode (
      .inst     (bus.imem_resp_data),
      .pc       (pc),
      .next_pc  (pd_next_pc),
      .bpu_jump (pd_bpu)
   );

   assign consume = out_valid & bus.id_ready & ~bus.id_stall;
   assign hs      = req_valid & bus.imem_req_ready;
   assign resp_in = (state == ST_WAIT) & bus.imem_resp_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         pc    <= RESET_PC;
         drop  <= 1'b0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         drop  <= drop_next;
      end
   end

   always_comb begin
      state_next = state;
      pc_next    = pc;
      drop_next  = drop;
      resp_take  = 1'b0;
      req_valid  = (state == ST_REQ) & ~skid_valid;

      case (state)
         ST_IDLE: state_next = ST_REQ;
         ST_REQ:  if (hs) state_next = ST_WAIT;
         ST_WAIT: begin
            if (resp_in) begin
               state_next = ST_REQ;
               if (drop) begin
                  drop_next = 1'b0;
               end else begin
                  resp_take = 1'b1;
                  pc_next   = pd_next_pc;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase

      // A redirect overrides everything. An already-issued fetch stays in WAIT with drop
      // set so its response is swallowed before the redirected fetch goes out.
      if (bus.jump_ena) begin
         pc_next   = bus.jump_pc & ~64'd3;
         resp_take = 1'b0;
         case (state)
            ST_REQ: begin
               state_next = hs ? ST_WAIT : ST_REQ;
               drop_next  = hs;
            end
            ST_WAIT: begin
               state_next = resp_in ? ST_REQ : ST_WAIT;
               drop_next  = ~resp_in;
            end
            default: state_next = ST_REQ;
         endcase
      end
   end

   // Requests are gated while the skid is full, so a response never meets a full skid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_inst   <= '0;
         out_pc     <= ZERO64;
         out_bpu    <= 1'b0;
         skid_valid <= 1'b0;
         skid_inst  <= '0;
         skid_pc    <= ZERO64;
         skid_bpu   <= 1'b0;
      end else if (bus.jump_ena) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (!out_valid || consume) begin
         if (skid_valid) begin
            out_valid  <= 1'b1;
            out_inst   <= skid_inst;
            out_pc     <= skid_pc;
            out_bpu    <= skid_bpu;
            skid_valid <= 1'b0;
         end else if (resp_take) begin
            out_valid <= 1'b1;
            out_inst  <= bus.imem_resp_data;
            out_pc    <= pc;
            out_bpu   <= pd_bpu;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (resp_take) begin
         skid_valid <= 1'b1;
         skid_inst  <= bus.imem_resp_data;
         skid_pc    <= pc;
         skid_bpu   <= pd_bpu;
      end
   end

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_addr      = pc;
   assign bus.if_valid       = out_valid;
   assign bus.inst_o         = out_inst;
   assign bus.pc_o           = out_pc;
   assign bus.bpu_jump_o     = out_bpu;
   assign state_dbg          = state;

endmodule

// File: tb/tb_ysyx_22051013_ifu_fetch.sv
// Directed bench for the fetch stage: reset, straight-line fetch, branch/JAL prediction,
// redirect with dropped response, decode stall with skid, and reset in the middle of a fetch.
module tb_ysyx_22051013_ifu_fetch;
   import ysyx_22051013_ifu_fetch_pkg::*;

   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] BEQM8 = 32'hFE00_0CE3;
   localparam logic [31:0] BEQP8 = 32'h0000_0463;
   localparam logic [31:0] JAL   = 32'h1000_006F;
   localparam logic [31:0] I1    = 32'h0010_0093;
   localparam logic [31:0] I2    = 32'h0020_0113;

   logic       clk = 1'b0;
   logic       rst;
   ifu_state_e state_dbg;
   int         n_checks = 0;
   int         n_pass = 0;

   ysyx_22051013_ifu_fetch_if bus ();

   ysyx_22051013_ifu_fetch dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, got, exp);
   endtask

   // imem model: accept the next request, then return data with a 1-cycle pulse.
   task automatic serve(input logic [31:0] data, input logic [63:0] exp_addr);
      int waited = 0;
      while (!bus.imem_req_valid && waited < 20) begin
         step();
         waited++;
      end
      chk("req_valid", 64'(bus.imem_req_valid), 64'd1);
      chk("req_addr", bus.imem_addr, exp_addr);
      step();
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = data;
      step();
      bus.imem_resp_valid = 1'b0;
   endtask

   initial begin
      rst                 = 1'b1;
      bus.imem_req_ready  = 1'b1;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
      bus.jump_ena        = 1'b0;
      bus.jump_pc         = '0;
      bus.id_ready        = 1'b1;
      bus.id_stall        = 1'b0;
      step();
      step();

      chk("rst_state", 64'(state_dbg), 64'(ST_IDLE));
      chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
      chk("rst_addr", bus.imem_addr, 64'h8000_0000);
      chk("rst_if_valid", 64'(bus.if_valid), 64'd0);
      chk("rst_inst", 64'(bus.inst_o), 64'd0);
      chk("rst_pc_o", bus.pc_o, 64'd0);
      chk("rst_bpu", 64'(bus.bpu_jump_o), 64'd0);

      rst = 1'b0;
      step();
      chk("first_state", 64'(state_dbg), 64'(ST_REQ));

      // straight-line NOP
      serve(NOP, 64'h8000_0000);
      chk("nop_if_valid", 64'(bus.if_valid), 64'd1);
      chk("nop_pc_o", bus.pc_o, 64'h8000_0000);
      chk("nop_inst", 64'(bus.inst_o), 64'h13);
      chk("nop_bpu", 64'(bus.bpu_jump_o), 64'd0);
      chk("nop_next_addr", bus.imem_addr, 64'h8000_0004);

      serve(NOP, 64'h8000_0004);
      serve(NOP, 64'h8000_0008);
      serve(NOP, 64'h8000_000C);

      // backward branch predicted taken
      serve(BEQM8, 64'h8000_0010);
      chk("beqm_pc_o", bus.pc_o, 64'h8000_0010);
      chk("beqm_bpu", 64'(bus.bpu_jump_o), 64'd1);
      chk("beqm_next_addr", bus.imem_addr, 64'h8000_0008);
      serve(NOP, 64'h8000_0008);
      serve(NOP, 64'h8000_000C);

      // forward branch falls through
      serve(BEQP8, 64'h8000_0010);
      chk("beqp_inst", 64'(bus.inst_o), 64'(BEQP8));
      chk("beqp_bpu", 64'(bus.bpu_jump_o), 64'd0);
      chk("beqp_next_addr", bus.imem_addr, 64'h8000_0014);

      // redirect while a fetch is outstanding
      chk("redir_req_valid", 64'(bus.imem_req_valid), 64'd1);
      step();
      chk("redir_wait", 64'(state_dbg), 64'(ST_WAIT));
      bus.jump_ena = 1'b1;
      bus.jump_pc  = 64'h8000_0203;
      step();
      bus.jump_ena = 1'b0;
      chk("redir_if_valid", 64'(bus.if_valid), 64'd0);
      chk("redir_addr", bus.imem_addr, 64'h8000_0200);
      chk("redir_no_req", 64'(bus.imem_req_valid), 64'd0);
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = I1;
      step();
      bus.imem_resp_valid = 1'b0;
      chk("drop_if_valid", 64'(bus.if_valid), 64'd0);
      chk("drop_req_valid", 64'(bus.imem_req_valid), 64'd1);
      chk("drop_addr", bus.imem_addr, 64'h8000_0200);
      serve(NOP, 64'h8000_0200);
      chk("redir_pc_o", bus.pc_o, 64'h8000_0200);
      chk("redir_valid2", 64'(bus.if_valid), 64'd1);

      // decode stall: second fetch lands in the skid, requests stop
      bus.id_stall = 1'b1;
      serve(I1, 64'h8000_0204);
      chk("stall_req_low", 64'(bus.imem_req_valid), 64'd0);
      chk("stall_if_valid", 64'(bus.if_valid), 64'd1);
      chk("stall_pc_o", bus.pc_o, 64'h8000_0200);
      chk("stall_inst", 64'(bus.inst_o), 64'(NOP));
      step();
      step();
      chk("stall_hold_req", 64'(bus.imem_req_valid), 64'd0);
      chk("stall_hold_pc_o", bus.pc_o, 64'h8000_0200);
      chk("stall_hold_addr", bus.imem_addr, 64'h8000_0208);
      bus.id_stall = 1'b0;
      step();
      chk("skid_pc_o", bus.pc_o, 64'h8000_0204);
      chk("skid_inst", 64'(bus.inst_o), 64'(I1));
      chk("skid_if_valid", 64'(bus.if_valid), 64'd1);
      chk("skid_req_back", 64'(bus.imem_req_valid), 64'd1);
      serve(I2, 64'h8000_0208);
      chk("after_pc_o", bus.pc_o, 64'h8000_0208);
      chk("after_inst", 64'(bus.inst_o), 64'(I2));
      step();
      chk("no_dup", 64'(bus.if_valid), 64'd0);
      chk("mid_wait", 64'(state_dbg), 64'(ST_WAIT));

      // reset in the middle of a fetch, stale response afterwards
      rst = 1'b1;
      #1;
      chk("mrst_state", 64'(state_dbg), 64'(ST_IDLE));
      chk("mrst_req_valid", 64'(bus.imem_req_valid), 64'd0);
      chk("mrst_addr", bus.imem_addr, 64'h8000_0000);
      chk("mrst_if_valid", 64'(bus.if_valid), 64'd0);
      chk("mrst_inst", 64'(bus.inst_o), 64'd0);
      chk("mrst_pc_o", bus.pc_o, 64'd0);
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = JAL;
      step();
      rst = 1'b0;
      step();
      bus.imem_resp_valid = 1'b0;
      chk("stale_if_valid", 64'(bus.if_valid), 64'd0);
      chk("stale_state", 64'(state_dbg), 64'(ST_REQ));
      chk("stale_addr", bus.imem_addr, 64'h8000_0000);

      // JAL handled inside fetch
      serve(JAL, 64'h8000_0000);
      chk("jal_pc_o", bus.pc_o, 64'h8000_0000);
      chk("jal_inst", 64'(bus.inst_o), 64'(JAL));
      chk("jal_bpu", 64'(bus.bpu_jump_o), 64'd0);
      chk("jal_next_addr", bus.imem_addr, 64'h8000_0100);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
